// File: rtl/led_sequencer_pkg.sv
// Shared types for the LED sequencer: FSM state, sweep direction, index width helper.
package led_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Width of the position index; a single LED still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-flop synchroniser, stability counter, rising-edge press pulse.
// A button already high when reset is released must be seen low once before it
// can produce a press, so a held button never fires on its own.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;   // marks when sync_q[1] holds a real post-reset sample
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;
  logic          arm_q, arm_d;

  // Synchroniser and its fill marker
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Count consecutive disagreeing samples; flip the level after a full stable run
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    arm_d   = arm_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (fill_q[1] && !sync_q[1]) arm_d = 1'b1;
  end

  // Debounce state and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      arm_q   <= arm_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = level_q & ~prev_q & arm_q;

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer top: two debounced buttons (advance / clear), wrap or ping-pong
// stepping over NUM_LEDS positions, optional timed auto-advance, registered outputs.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int NUM_LEDS        = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_button0,
  input  logic                push_button1,
  input  logic                mode_bounce,
  input  logic                auto_en,
  output logic [NUM_LEDS-1:0] led,
  output logic                idle
);

  localparam int            IW       = idx_w(NUM_LEDS);
  localparam int            TW       = $clog2(AUTO_PERIOD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LEDS - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_PERIOD - 1);

  logic [1:0] btn_raw, btn_level, btn_press;
  logic       unused_level;

  assign btn_raw      = {push_button1, push_button0};
  assign unused_level = ^btn_level;

  for (genvar b = 0; b < 2; b++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[b]),
      .level      (btn_level[b]),
      .press_pulse(btn_press[b])
    );
  end

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                idle_q, idle_d;
  logic                tick, adv, clr;

  assign tick = (state_q == ST_RUN) && auto_en && (timer_q == TMR_LAST);
  assign adv  = btn_press[0] | tick;
  assign clr  = btn_press[1];

  // Next position/direction, auto timer, and outputs from the next state
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    led_d   = '0;
    idle_d  = 1'b1;

    // Any step or clear restarts the full period; only counts while running with auto on
    if (clr || adv || !auto_en || state_q == ST_IDLE) timer_d = '0;
    else                                               timer_d = timer_q + 1'b1;

    if (clr) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      dir_d   = DIR_UP;
    end else if (adv) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_RUN;
        idx_d   = '0;
        dir_d   = DIR_UP;
      end else if (NUM_LEDS == 1) begin
        idx_d = '0;
        dir_d = DIR_UP;
      end else if (!mode_bounce) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        dir_d = DIR_UP;
      end else if (dir_q == DIR_UP) begin
        if (idx_q == IDX_LAST) begin
          idx_d = idx_q - 1'b1;
          dir_d = DIR_DOWN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          idx_d = idx_q + 1'b1;
          dir_d = DIR_UP;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_LEDS; i++) led_d[i] = (state_d == ST_RUN) && (idx_d == IW'(i));
    idle_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      idx_q   <= '0;
      timer_q <= '0;
      led_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      idle_q  <= idle_d;
    end
  end

  assign led  = led_q;
  assign idle = idle_q;

endmodule
